// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and defaults for the Wishbone configuration-port arbiter.
//   wb_arb_state_t : master FSM states (idle, bus cycle open, settle gap)
//   WB_AW_DEFAULT  : default Wishbone address width
//   WB_DW_DEFAULT  : default Wishbone data width
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_AW_DEFAULT = 32;
    localparam int WB_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } wb_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The winner is the first requester with
// its bit set, searching upward from the one after the last winner and
// wrapping around. The pointer register is owned by the instantiating block.
// Ports:
//   i_req   [N_REQ]        request vector
//   i_ptr   [log2 N_REQ]   index of the most recent winner
//   o_any   [1]            at least one request present
//   o_grant [N_REQ]        one-hot winner (all zero when o_any = 0)
//   o_idx   [log2 N_REQ]   binary winner index (0 when o_any = 0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic                     o_any,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    // Doubling the request vector lets a plain right shift act as a rotate:
    // bit k of w_rot is requester (ptr + 1 + k) mod N_REQ.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N_REQ'(w_dbl >> (int'(i_ptr) + 1));
    assign o_any = |w_rot;

    // Scan from the far end down so the lowest rotated position, i.e. the
    // nearest requester after the pointer, is the one left standing.
    always_comb begin
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx = IW'((int'(i_ptr) + 1 + k) % N_REQ);
            end
        end
    end

    // Expand the binary winner into the one-hot grant.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N_REQ; j++) begin
            o_grant[j] = o_any && (o_idx == IW'(j));
        end
    end

endmodule

// File: rtl/wb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// wb_cfg_arbiter
// Wishbone classic master sharing one slave port between N_REQ local
// requesters. One single transfer at a time, round-robin fairness, a bounded
// wait for ACK_I and a fixed idle gap after every transfer so the slave can
// settle before the next cycle opens.
// Ports:
//   CLK_I, RST_I          clock (rising edge) / async reset, active low
//   req_valid_i [N]       per-requester request, held with payload until done
//   req_we_i    [N]       per-requester write enable
//   req_adr_i   [N*AW]    flattened addresses, requester k at [k*AW +: AW]
//   req_dat_i   [N*DW]    flattened write data
//   done_o      [N]       one-cycle pulse when requester k's transfer ends
//   err_o       [N]       one-cycle pulse with done_o when ended by timeout
//   rdata_o     [DW]      read data, updated on a successful read, held after
//   busy_o                high whenever the FSM is not idle
//   CYC_O/STB_O/WE_O/ADR_O/DAT_O   Wishbone master outputs
//   DAT_I/ACK_I           Wishbone slave response
// ---------------------------------------------------------------------------
module wb_cfg_arbiter
    import wb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int AW          = WB_AW_DEFAULT,
    parameter int DW          = WB_DW_DEFAULT,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 45
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ-1:0]    req_we_i,
    input  logic [N_REQ*AW-1:0] req_adr_i,
    input  logic [N_REQ*DW-1:0] req_dat_i,
    output logic [N_REQ-1:0]    done_o,
    output logic [N_REQ-1:0]    err_o,
    output logic [DW-1:0]       rdata_o,
    output logic                busy_o,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [AW-1:0]       ADR_O,
    output logic [DW-1:0]       DAT_O,
    input  logic [DW-1:0]       DAT_I,
    input  logic                ACK_I
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    wb_arb_state_t    r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gidx;
    logic [N_REQ-1:0] r_gnt;
    logic [TW-1:0]    r_tmo;
    logic [GW-1:0]    r_gap;
    logic             r_cyc;
    logic             r_we;
    logic [AW-1:0]    r_adr;
    logic [DW-1:0]    r_dat;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_err;
    logic [DW-1:0]    r_rdata;

    logic             w_any;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_tmo_last;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_tmo_last = (r_tmo == TW'(TIMEOUT_CYC - 1));

    // Master FSM with all bus-facing outputs registered. ACK_I is only
    // looked at in ST_BUS, so stray acknowledges elsewhere are harmless.
    // When ACK_I and the last timeout cycle coincide the ACK is honoured.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= ST_IDLE;
            r_ptr   <= IW'(N_REQ - 1);
            r_gidx  <= '0;
            r_gnt   <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gidx  <= w_idx;
                        r_gnt   <= w_grant;
                        r_we    <= req_we_i[w_idx];
                        r_adr   <= req_adr_i[int'(w_idx)*AW +: AW];
                        r_dat   <= req_dat_i[int'(w_idx)*DW +: DW];
                        r_cyc   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (ACK_I || w_tmo_last) begin
                        r_cyc  <= 1'b0;
                        r_we   <= 1'b0;
                        r_adr  <= '0;
                        r_dat  <= '0;
                        r_done <= r_gnt;
                        r_err  <= ACK_I ? '0 : r_gnt;
                        if (ACK_I && !r_we) begin
                            r_rdata <= DAT_I;
                        end
                        r_ptr   <= r_gidx;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (r_state != ST_IDLE);
    assign CYC_O   = r_cyc;
    assign STB_O   = r_cyc;
    assign WE_O    = r_we;
    assign ADR_O   = r_adr;
    assign DAT_O   = r_dat;
    assign done_o  = r_done;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_cfg_arbiter
// Directed bench for wb_cfg_arbiter with default parameters (2 requesters,
// 32-bit bus, 64-cycle timeout, 45-cycle gap). A table of complete transfers
// exercises arbitration order, payload routing and read capture; short
// hand-written sequences cover timeout, ACK on the final timeout cycle,
// stray acknowledges and reset in the middle of a bus cycle.
// ---------------------------------------------------------------------------
module tb_wb_cfg_arbiter;

    localparam int GAP = 45;
    localparam int TMO = 64;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [1:0]  req_valid_i = '0;
    logic [1:0]  req_we_i = '0;
    logic [63:0] req_adr_i = '0;
    logic [63:0] req_dat_i = '0;
    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I = '0;
    logic        ACK_I = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] adr0;
        logic [31:0] adr1;
        logic [31:0] dat0;
        logic [31:0] dat1;
        logic [31:0] dati;
        int          ackDelay;
        logic [1:0]  expDone;
        logic        expWe;
        logic [31:0] expAdr;
        logic [31:0] expDat;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [8];

    wb_cfg_arbiter dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .req_valid_i (req_valid_i),
        .req_we_i    (req_we_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .CYC_O       (CYC_O),
        .STB_O       (STB_O),
        .WE_O        (WE_O),
        .ADR_O       (ADR_O),
        .DAT_O       (DAT_O),
        .DAT_I       (DAT_I),
        .ACK_I       (ACK_I)
    );

    // 100 MHz clock.
    always #5 CLK_I = ~CLK_I;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=expired required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic waitBusyLow();
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        checkOutput("returnToIdle", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic waitCycHigh(output int n);
        n = 0;
        while (!CYC_O && n < 200) begin
            tick();
            n++;
        end
        checkOutput("cycRise", {63'd0, CYC_O}, 64'd1);
    endtask

    // One full transfer from IDLE: launch, bus-phase checks, ACK after
    // ackDelay cycles of CYC_O, completion checks, then the settle gap.
    task automatic applyStimulus(input int idx, input vec_t v);
        int  n;
        logic cycInGap;
        logic doneInGap;
        req_we_i    = v.we;
        req_adr_i   = {v.adr1, v.adr0};
        req_dat_i   = {v.dat1, v.dat0};
        req_valid_i = v.valid;
        tick();
        checkOutput($sformatf("v%0d cycLatency", idx), {63'd0, CYC_O}, 64'd1);
        checkOutput($sformatf("v%0d stb", idx), {63'd0, STB_O}, 64'd1);
        checkOutput($sformatf("v%0d adr", idx), {32'd0, ADR_O}, {32'd0, v.expAdr});
        checkOutput($sformatf("v%0d we", idx), {63'd0, WE_O}, {63'd0, v.expWe});
        checkOutput($sformatf("v%0d dat", idx), {32'd0, DAT_O}, {32'd0, v.expDat});
        for (int i = 1; i < v.ackDelay; i++) begin
            tick();
        end
        ACK_I = 1'b1;
        DAT_I = v.dati;
        checkOutput($sformatf("v%0d cycHeld", idx), {63'd0, CYC_O}, 64'd1);
        checkOutput($sformatf("v%0d adrHeld", idx), {32'd0, ADR_O}, {32'd0, v.expAdr});
        checkOutput($sformatf("v%0d weHeld", idx), {63'd0, WE_O}, {63'd0, v.expWe});
        tick();
        ACK_I = 1'b0;
        DAT_I = '0;
        checkOutput($sformatf("v%0d cycDrop", idx), {63'd0, CYC_O}, 64'd0);
        checkOutput($sformatf("v%0d adrClear", idx), {32'd0, ADR_O}, 64'd0);
        checkOutput($sformatf("v%0d done", idx), {62'd0, done_o}, {62'd0, v.expDone});
        checkOutput($sformatf("v%0d err", idx), {62'd0, err_o}, 64'd0);
        checkOutput($sformatf("v%0d rdata", idx), {32'd0, rdata_o}, {32'd0, v.expRdata});
        // Winner drops its request; the loser keeps asking through the gap,
        // which must not reopen the bus early.
        req_valid_i = v.valid & ~v.expDone;
        n = 0;
        cycInGap  = 1'b0;
        doneInGap = 1'b0;
        while (busy_o && n < 200) begin
            cycInGap = cycInGap | CYC_O;
            if (n > 0) begin
                doneInGap = doneInGap | (|done_o);
            end
            n++;
            tick();
        end
        req_valid_i = '0;
        checkOutput($sformatf("v%0d gapLen", idx), 64'(n), 64'(GAP));
        checkOutput($sformatf("v%0d cycInGap", idx), {63'd0, cycInGap}, 64'd0);
        checkOutput($sformatf("v%0d donePulse", idx), {63'd0, doneInGap}, 64'd0);
    endtask

    initial begin
        int   n;
        logic stray;

        // Reset is applied from time 0; ptr starts at 1 so requester 0 wins first.
        vecs[0] = '{valid:2'b11, we:2'b11, adr0:32'h0,  adr1:32'h8,  dat0:32'h30201, dat1:32'h55,
                    dati:32'hFFFF_FFFF, ackDelay:3, expDone:2'b01, expWe:1'b1,
                    expAdr:32'h0,  expDat:32'h30201, expRdata:32'h0};
        vecs[1] = '{valid:2'b11, we:2'b11, adr0:32'h0,  adr1:32'h8,  dat0:32'h30201, dat1:32'h55,
                    dati:32'hFFFF_FFFF, ackDelay:2, expDone:2'b10, expWe:1'b1,
                    expAdr:32'h8,  expDat:32'h55, expRdata:32'h0};
        vecs[2] = '{valid:2'b11, we:2'b11, adr0:32'h10, adr1:32'h14, dat0:32'hA0, dat1:32'hB1,
                    dati:32'hFFFF_FFFF, ackDelay:1, expDone:2'b01, expWe:1'b1,
                    expAdr:32'h10, expDat:32'hA0, expRdata:32'h0};
        vecs[3] = '{valid:2'b11, we:2'b11, adr0:32'h10, adr1:32'h14, dat0:32'hA0, dat1:32'hB1,
                    dati:32'hFFFF_FFFF, ackDelay:4, expDone:2'b10, expWe:1'b1,
                    expAdr:32'h14, expDat:32'hB1, expRdata:32'h0};
        vecs[4] = '{valid:2'b10, we:2'b00, adr0:32'h0,  adr1:32'h4,  dat0:32'h0, dat1:32'h77,
                    dati:32'hDEAD_BEEF, ackDelay:2, expDone:2'b10, expWe:1'b0,
                    expAdr:32'h4,  expDat:32'h77, expRdata:32'hDEAD_BEEF};
        vecs[5] = '{valid:2'b01, we:2'b01, adr0:32'hC,  adr1:32'h4,  dat0:32'h1234, dat1:32'h0,
                    dati:32'hFFFF_FFFF, ackDelay:1, expDone:2'b01, expWe:1'b1,
                    expAdr:32'hC,  expDat:32'h1234, expRdata:32'hDEAD_BEEF};
        vecs[6] = '{valid:2'b11, we:2'b00, adr0:32'h24, adr1:32'h20, dat0:32'h0, dat1:32'h0,
                    dati:32'hCAFE_F00D, ackDelay:2, expDone:2'b10, expWe:1'b0,
                    expAdr:32'h20, expDat:32'h0, expRdata:32'hCAFE_F00D};
        vecs[7] = '{valid:2'b01, we:2'b00, adr0:32'h24, adr1:32'h20, dat0:32'h0, dat1:32'h0,
                    dati:32'h0BAD_C0DE, ackDelay:3, expDone:2'b01, expWe:1'b0,
                    expAdr:32'h24, expDat:32'h0, expRdata:32'h0BAD_C0DE};

        // Reset state.
        repeat (2) tick();
        checkOutput("rstCyc",   {63'd0, CYC_O},   64'd0);
        checkOutput("rstStb",   {63'd0, STB_O},   64'd0);
        checkOutput("rstWe",    {63'd0, WE_O},    64'd0);
        checkOutput("rstAdr",   {32'd0, ADR_O},   64'd0);
        checkOutput("rstBusy",  {63'd0, busy_o},  64'd0);
        checkOutput("rstDone",  {62'd0, done_o},  64'd0);
        checkOutput("rstRdata", {32'd0, rdata_o}, 64'd0);
        @(negedge CLK_I);
        RST_I = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Timeout: requester 0 write with no ACK; CYC_O stays up 64 cycles.
        req_we_i    = 2'b11;
        req_adr_i   = {32'h44, 32'h40};
        req_dat_i   = {32'h2, 32'h1};
        req_valid_i = 2'b01;
        tick();
        checkOutput("tmoCycStart", {63'd0, CYC_O}, 64'd1);
        n = 0;
        while (CYC_O && n < 200) begin
            n++;
            tick();
        end
        checkOutput("tmoCycLen", 64'(n), 64'(TMO));
        checkOutput("tmoDone",   {62'd0, done_o},  64'd1);
        checkOutput("tmoErr",    {62'd0, err_o},   64'd1);
        checkOutput("tmoRdata",  {32'd0, rdata_o}, 64'h0BAD_C0DE);
        // Next request waits out the gap plus the arbitration cycle.
        req_valid_i = 2'b10;
        waitCycHigh(n);
        checkOutput("tmoNextDelay", 64'(n), 64'(GAP + 1));
        checkOutput("tmoNextAdr",   {32'd0, ADR_O}, 64'h44);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        checkOutput("tmoNextDone", {62'd0, done_o}, 64'd2);
        checkOutput("tmoNextErr",  {62'd0, err_o},  64'd0);
        req_valid_i = '0;
        waitBusyLow();

        // ACK on the last timeout cycle wins over the timeout.
        req_we_i    = 2'b00;
        req_adr_i   = {32'h54, 32'h50};
        req_valid_i = 2'b01;
        tick();
        checkOutput("lastCycStart", {63'd0, CYC_O}, 64'd1);
        repeat (TMO - 1) tick();
        checkOutput("lastCycHeld", {63'd0, CYC_O}, 64'd1);
        ACK_I = 1'b1;
        DAT_I = 32'h1111_2222;
        tick();
        ACK_I = 1'b0;
        DAT_I = '0;
        req_valid_i = '0;
        checkOutput("lastCycDrop",  {63'd0, CYC_O},   64'd0);
        checkOutput("lastCycDone",  {62'd0, done_o},  64'd1);
        checkOutput("lastCycErr",   {62'd0, err_o},   64'd0);
        checkOutput("lastCycRdata", {32'd0, rdata_o}, 64'h1111_2222);

        // Stray ACK_I during the gap and while idle.
        ACK_I = 1'b1;
        DAT_I = 32'hFFFF_FFFF;
        stray = 1'b0;
        repeat (5) begin
            tick();
            stray = stray | CYC_O | (|done_o) | (|err_o);
        end
        ACK_I = 1'b0;
        checkOutput("strayGap", {63'd0, stray}, 64'd0);
        waitBusyLow();
        ACK_I = 1'b1;
        stray = 1'b0;
        repeat (3) begin
            tick();
            stray = stray | busy_o | (|done_o);
        end
        ACK_I = 1'b0;
        DAT_I = '0;
        checkOutput("strayIdle",  {63'd0, stray},   64'd0);
        checkOutput("strayRdata", {32'd0, rdata_o}, 64'h1111_2222);

        // Reset mid-BUS: requester 1 on the bus, reset asserted between edges.
        req_we_i    = 2'b11;
        req_adr_i   = {32'h60, 32'h70};
        req_dat_i   = {32'h6, 32'h7};
        req_valid_i = 2'b10;
        tick();
        checkOutput("rstBusCyc", {63'd0, CYC_O}, 64'd1);
        tick();
        req_valid_i = 2'b11;
        #3;
        RST_I = 1'b0;
        #1;
        checkOutput("rstMidCyc",  {63'd0, CYC_O},  64'd0);
        checkOutput("rstMidStb",  {63'd0, STB_O},  64'd0);
        checkOutput("rstMidBusy", {63'd0, busy_o}, 64'd0);
        tick();
        checkOutput("rstMidDone", {62'd0, done_o}, 64'd0);
        @(negedge CLK_I);
        RST_I = 1'b1;
        tick();
        checkOutput("rstAfterCyc", {63'd0, CYC_O}, 64'd1);
        checkOutput("rstAfterAdr", {32'd0, ADR_O}, 64'h70);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        req_valid_i = '0;
        checkOutput("rstAfterDone", {62'd0, done_o}, 64'd1);
        waitBusyLow();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
